countdown_ctrl: RTL and testbench

//  Sequencer for a cascaded chain of DownCounter digit stages forming a countdown timer.
//  It loads the preset, generates the per-tick count enable for the least-significant

---
 rtl/countdown_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequencer for a cascaded chain of down-counting digit stages.
//
// Loads the preset into every digit, divides the clock down to a per-tick count enable for
// the least-significant digit, detects expiry from the datapath all-zero flag, then raises
// done and a timed alarm.
//
// Ports
//   clk_i        system clock, all state on posedge
//   rst_ni       asynchronous active-low reset
//   start_i      pulse: begin/continue countdown
//   pause_i      pulse: toggle run <-> pause
//   clear_i      pulse: abort to idle
//   set_i        pulse: load preset into the digit counters
//   all_zero_i   every digit count is zero (from datapath)
//   cnt_load_o   1-cycle load pulse to every digit stage
//   cnt_ce_o     1-cycle count enable to the LSD stage, once per tick
//   busy_o       high in run or pause
//   done_o       high in done
//   alarm_o      toggles once per tick for ALARM_TICKS ticks after expiry
//   state_o      Idle=0 Armed=1 Run=2 Pause=3 Done=4
//
// Input priority in one cycle: clear > set > start > pause.

module countdown_ctrl #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned DIV_W       = 27,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       clear_i,
  input  logic       set_i,
  input  logic       all_zero_i,
  output logic       cnt_load_o,
  output logic       cnt_ce_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic [2:0] state_o
);

  localparam int unsigned AlmW = $clog2(ALARM_TICKS + 1);
  localparam logic [DIV_W-1:0] TickMax  = DIV_W'(TICK_DIV - 1);
  localparam logic [AlmW-1:0]  AlarmMax = AlmW'(ALARM_TICKS);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [AlmW-1:0]  alm_cnt_q;
  logic             cnt_load_q;
  logic             cnt_ce_q;
  logic             busy_q;
  logic             done_q;
  logic             alarm_q;

  // Prescaler wrap and its free-running successor value.
  logic             wrap;
  logic [DIV_W-1:0] presc_nxt;

  always_comb begin
    wrap      = (presc_q == TickMax);
    presc_nxt = wrap ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      alm_cnt_q  <= '0;
      cnt_load_q <= 1'b0;
      cnt_ce_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them for one cycle.
      cnt_load_q <= 1'b0;
      cnt_ce_q   <= 1'b0;
      if (clear_i) begin
        state_q   <= StIdle;
        presc_q   <= '0;
        alm_cnt_q <= '0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        alarm_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (set_i) begin
              cnt_load_q <= 1'b1;
              presc_q    <= '0;
              state_q    <= StArmed;
            end
          end
          StArmed: begin
            if (set_i) begin
              cnt_load_q <= 1'b1;
            end else if (start_i) begin
              presc_q <= '0;
              if (all_zero_i) begin
                // Nothing to count: expire without issuing any tick.
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
                busy_q  <= 1'b1;
              end
            end
          end
          StRun: begin
            if (all_zero_i) begin
              // Expiry wins over a pending tick; prescaler keeps running for the alarm.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              presc_q <= presc_nxt;
            end else if (pause_i && !set_i && !start_i) begin
              // set/start outrank pause and consume the cycle even though they do nothing here.
              state_q <= StPause;
            end else begin
              presc_q  <= presc_nxt;
              cnt_ce_q <= wrap;
            end
          end
          StPause: begin
            if (set_i) begin
              cnt_load_q <= 1'b1;
              presc_q    <= '0;
              busy_q     <= 1'b0;
              state_q    <= StArmed;
            end else if (start_i || pause_i) begin
              state_q <= StRun;
            end
          end
          StDone: begin
            if (set_i) begin
              cnt_load_q <= 1'b1;
              presc_q    <= '0;
              alm_cnt_q  <= '0;
              alarm_q    <= 1'b0;
              done_q     <= 1'b0;
              state_q    <= StArmed;
            end else begin
              presc_q <= presc_nxt;
              if (wrap) begin
                // Toggle for ALARM_TICKS wraps, then park the alarm low.
                if (alm_cnt_q < AlarmMax) begin
                  alm_cnt_q <= alm_cnt_q + 1'b1;
                  alarm_q   <= ~alarm_q;
                end else begin
                  alarm_q <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_q   <= StIdle;
            presc_q   <= '0;
            alm_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_load_o = cnt_load_q;
  assign cnt_ce_o   = cnt_ce_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign alarm_o    = alarm_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=4, ALARM_TICKS=3.
// Inputs change 1 time unit after a posedge; outputs are sampled at the same point, so each
// check sees the result of the edge that sampled the preceding inputs.

module tb_countdown_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       start_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       set_i = 1'b0;
  logic       all_zero_i = 1'b0;
  logic       cnt_load_o;
  logic       cnt_ce_o;
  logic       busy_o;
  logic       done_o;
  logic       alarm_o;
  logic [2:0] state_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  countdown_ctrl #(
    .TICK_DIV   (4),
    .DIV_W      (3),
    .ALARM_TICKS(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .pause_i   (pause_i),
    .clear_i   (clear_i),
    .set_i     (set_i),
    .all_zero_i(all_zero_i),
    .cnt_load_o(cnt_load_o),
    .cnt_ce_o  (cnt_ce_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .alarm_o   (alarm_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // All outputs packed: {load, ce, busy, done, alarm, state[2:0]}.
  function automatic logic [7:0] outs();
    return {cnt_load_o, cnt_ce_o, busy_o, done_o, alarm_o, state_o};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Async reset asserted before any clock edge.
    #1 rst_ni = 1'b0;
    #1 check("reset_async_outs", outs(), 8'h00);
    #10 rst_ni = 1'b1;
    cyc();
    check("after_reset", outs(), 8'h00);

    // start/pause ignored in Idle.
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("idle_ignore_start", {5'd0, state_o}, 8'd0);

    // set in Idle: one-cycle load, go Armed.
    set_i = 1'b1; cyc(); set_i = 1'b0;
    check("set_load_pulse", {7'd0, cnt_load_o}, 8'd1);
    check("set_state_armed", {5'd0, state_o}, 8'd1);
    cyc();
    check("load_one_cycle", {7'd0, cnt_load_o}, 8'd0);

    // start with all_zero=0: Run, tick every 4 cycles, first one 4 cycles after start edge.
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("start_state_run", {5'd0, state_o}, 8'd2);
    check("start_busy", {7'd0, busy_o}, 8'd1);
    check("start_ce0", {7'd0, cnt_ce_o}, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("run_ce_k%0d", k), {7'd0, cnt_ce_o}, {7'd0, (k % 4) == 0});
    end

    // Two cycles into the tick, then pause at the third edge; prescaler holds at 2.
    cyc(); check("pre_pause_ce_a", {7'd0, cnt_ce_o}, 8'd0);
    cyc(); check("pre_pause_ce_b", {7'd0, cnt_ce_o}, 8'd0);
    pause_i = 1'b1; cyc(); pause_i = 1'b0;
    check("pause_state", {5'd0, state_o}, 8'd3);
    check("pause_busy", {7'd0, busy_o}, 8'd1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      check($sformatf("paused_k%0d", k), {cnt_ce_o, 4'd0, state_o}, 8'h03);
    end
    pause_i = 1'b1; cyc(); pause_i = 1'b0;
    check("resume_state", {cnt_ce_o, 4'd0, state_o}, 8'h02);
    cyc(); check("resume_ce_1", {7'd0, cnt_ce_o}, 8'd0);
    cyc(); check("resume_ce_2", {7'd0, cnt_ce_o}, 8'd1);

    // Expiry: Done next cycle; alarm 1 at wrap 1, 0 at 2, 1 at 3, then 0 from wrap 4 on.
    all_zero_i = 1'b1; cyc();
    check("expire_outs", outs(), 8'b0001_0100);
    for (int k = 1; k <= 20; k++) begin
      logic exp_al;
      cyc();
      exp_al = ((k >= 3 && k <= 6) || (k >= 11 && k <= 14));
      check($sformatf("done_k%0d", k), outs(), {3'b000, 1'b1, exp_al, 3'd4});
    end

    // set in Done: reload, Armed, done and alarm cleared.
    all_zero_i = 1'b0;
    set_i = 1'b1; cyc(); set_i = 1'b0;
    check("done_set_outs", outs(), 8'b1000_0001);

    // clear+set together in Run: clear wins, no load.
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc(); cyc();
    clear_i = 1'b1; set_i = 1'b1; cyc(); clear_i = 1'b0; set_i = 1'b0;
    check("clear_set_outs", outs(), 8'h00);
    cyc();
    check("clear_set_after", outs(), 8'h00);

    // Reset mid-Run between edges: outputs drop without a clock.
    set_i = 1'b1; cyc(); set_i = 1'b0;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc();
    check("pre_reset_busy", {5'd0, state_o}, 8'd2);
    #2 rst_ni = 1'b0;
    #1 check("midrun_reset_outs", outs(), 8'h00);
    #3 rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("post_reset_k%0d", k), outs(), 8'h00);
    end

    // start in Armed with all_zero=1: straight to Done, no ticks.
    set_i = 1'b1; cyc(); set_i = 1'b0;
    all_zero_i = 1'b1;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("zero_start_outs", outs(), 8'b0001_0100);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("zero_start_ce_k%0d", k), {cnt_ce_o, busy_o, done_o, 2'b00, state_o},
            8'b0010_0100);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
